regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of the 4 x 8-bit register file between two writeback requesters (port 0: core ALU/load writeback, port 1: debug/host loader), and adds a hardware clear sequence that zeroes all four registers. It sits directly in front of the register file and drives its write-enable, write-address and write-data inputs from registered outputs. Arbitration is round-robin with valid/ready handshakes; at most one register write is issued per cycle.

## Interface
- No parameters; widths are fixed: 4 registers, 2-bit address, 8-bit data.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has a write pending.
- req0_addr  in  2  port 0 target register.
- req0_data  in  8  port 0 write value.
- req0_ready  out  1  port 0 transfer accepted this cycle (combinational).
- req1_valid / req1_addr / req1_data / req1_ready  same as port 0, for port 1.
- clear_req  in  1  single-cycle request to zero all registers.
- busy  out  1  clear sequence in progress.
- RegWrite_Enable  out  1  write strobe to the register file (registered).
- WriteRegister  out  2  write address (registered).
- WriteData  out  8  write data (registered).
- grant_id  out  1  port that won the most recent transfer (registered).

## Operation
- States: IDLE, CLEAR. 2-bit clear counter cnt. 1-bit last_grant pointer.
- Transfer: reqN_valid && reqN_ready at a rising edge.
- Readiness in IDLE with clear_req low:
  - Only one valid: that port is ready.
  - Both valid: the port != last_grant is ready and the other is not.
- Both readies are 0 whenever state==CLEAR or clear_req==1.
- Transfer from port N at edge E:
  - Output registers load (1, reqN_addr, reqN_data).
  - last_grant <= N and grant_id <= N.
- IDLE edge with clear_req==1:
  - Outputs load (1, 0, 8'h00), cnt <= 1, state <= CLEAR.
  - Any concurrent valid is not accepted.
- CLEAR edge:
  - Outputs load (1, cnt, 8'h00) and cnt <= cnt+1.
  - If cnt==3, state <= IDLE.
- clear_req while in CLEAR is ignored, with no restart or extension.
- busy = (state==CLEAR).
- Edge with no transfer and no clear activity: RegWrite_Enable <= 0. WriteRegister and WriteData hold their last values.
- last_grant changes only on a transfer. Clear writes do not change last_grant or grant_id.
- Requesters hold addr and data stable while valid is high and ready is low. A port may drop valid without a transfer.

## Timing
- Reset values, applied immediately and asynchronously:
  - RegWrite_Enable=0, WriteRegister=0, WriteData=0, grant_id=0.
  - busy=0, state=IDLE, cnt=0.
  - last_grant=1, so port 0 wins the first contest.
- Latency: a transfer accepted at the edge ending cycle N gives RegWrite_Enable=1 with that addr/data in cycle N+1. The register file captures it at the end of N+1.
- Throughput: one transfer per cycle. Back-to-back transfers from alternating or the same port are allowed.
- Clear accepted at the end of cycle N:
  - Strobes in cycles N+1..N+4 target registers 0,1,2,3, all with data 0.
  - busy is high in N+1..N+3.
  - Readies may go high in N+4, so a transfer there writes in N+5, after the clear completes.
- Reset asserted mid-clear or mid-transfer aborts it. The block returns to IDLE with all outputs at reset values, and the pending strobe is dropped.

## Test plan
- Reset, then port 0 only: addr 2, data 8'hA5 -> req0_ready=1 in the same cycle; next cycle RegWrite_Enable=1, WriteRegister=2, WriteData=8'hA5, grant_id=0; following idle cycle RegWrite_Enable=0.
- Both ports valid continuously for 4 cycles (p0: r1/8'h11, p1: r3/8'h33) -> grants alternate 0,1,0,1; strobes alternate r1/8'h11 and r3/8'h33 with no idle cycle.
- Write 8'hFF to all registers, then pulse clear_req -> four consecutive strobes to r0..r3 with data 8'h00; busy high for exactly 3 cycles; register file DebugOut reads 32'h00000000 afterwards.
- clear_req concurrent with req1_valid in IDLE -> req1_ready=0 that cycle; clear proceeds; port 1 is accepted in the cycle busy falls, and its write appears immediately after the r3 clear strobe.
- clear_req pulsed again mid-clear -> exactly four clear strobes total, no restart.
- Reset asserted in the second clear cycle -> RegWrite_Enable=0 and busy=0 immediately; after release, port 0 wins a contest against port 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of a 4 x 8-bit register file between two
//   writeback requesters, and provides a hardware clear sequence that zeroes
//   all four registers on consecutive cycles.
//
//   Ports
//     clk, reset                 rising-edge clock, async active-high reset
//     req0_valid/addr/data       port 0 (core writeback) request
//     req0_ready                 port 0 accepted this cycle (combinational)
//     req1_valid/addr/data       port 1 (debug/host loader) request
//     req1_ready                 port 1 accepted this cycle (combinational)
//     clear_req                  one-cycle request to zero all registers
//     busy                       clear sequence in progress
//     RegWrite_Enable            registered write strobe to the register file
//     WriteRegister              registered write address
//     WriteData                  registered write data
//     grant_id                   port that won the most recent transfer
module regfile_write_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [1:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic       RegWrite_Enable,
  output logic [1:0] WriteRegister,
  output logic [7:0] WriteData,
  output logic       grant_id
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       last_grant, last_grant_nxt;
  logic       we_nxt;
  logic [1:0] wa_nxt;
  logic [7:0] wd_nxt;
  logic       gid_nxt;

  assign busy = (state == CLEAR);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    we_nxt         = 1'b0;
    wa_nxt         = WriteRegister;
    wd_nxt         = WriteData;
    gid_nxt        = grant_id;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          // Clear wins over any pending request; register 0 is written now,
          // the counter walks registers 1..3 in the following cycles.
          we_nxt    = 1'b1;
          wa_nxt    = 2'd0;
          wd_nxt    = 8'h00;
          cnt_nxt   = 2'd1;
          state_nxt = CLEAR;
        end else begin
          if (req0_valid && req1_valid) begin
            // Contest: the port that did not win last time goes first.
            req0_ready = last_grant;
            req1_ready = ~last_grant;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end

          if (req0_valid && req0_ready) begin
            we_nxt         = 1'b1;
            wa_nxt         = req0_addr;
            wd_nxt         = req0_data;
            last_grant_nxt = 1'b0;
            gid_nxt        = 1'b0;
          end else if (req1_valid && req1_ready) begin
            we_nxt         = 1'b1;
            wa_nxt         = req1_addr;
            wd_nxt         = req1_data;
            last_grant_nxt = 1'b1;
            gid_nxt        = 1'b1;
          end
        end
      end

      CLEAR: begin
        // clear_req is deliberately ignored here: no restart, no extension.
        we_nxt  = 1'b1;
        wa_nxt  = cnt;
        wd_nxt  = 8'h00;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Registered stage driving the register-file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      last_grant      <= 1'b1;
      RegWrite_Enable <= 1'b0;
      WriteRegister   <= 2'd0;
      WriteData       <= 8'h00;
      grant_id        <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      last_grant      <= last_grant_nxt;
      RegWrite_Enable <= we_nxt;
      WriteRegister   <= wa_nxt;
      WriteData       <= wd_nxt;
      grant_id        <= gid_nxt;
    end
  end

endmodule
